// File: rtl/mem_responder.sv
// Byte RAM plus memory-mapped TX/RX byte FIFOs and a sticky halt flag.
// CPU-side accesses are gated by rdy; the external FIFO sides are not.
module mem_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        wr_in,
    output logic [7:0]  data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        io_full,
    output logic        halt
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0] mem    [2**RAM_AW];
    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_AW:0] tx_count;
    logic             tx_ovf;

    logic              io;
    logic [2:0]        off;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_we;
    logic              data_sel, stat_sel;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_pop, tx_push_req, tx_push;
    logic              rx_push, rx_pop;
    logic [7:0]        status;
    logic              unused_bits;

    assign io       = addr_in[17:16] == 2'b11;
    assign off      = addr_in[2:0];
    assign ram_a    = addr_in[RAM_AW-1:0];
    assign ram_we   = rdy & ~io & wr_in & ~rst;
    assign data_sel = rdy & io & (off == 3'd0);
    assign stat_sel = rdy & io & (off == 3'd4);

    assign unused_bits = ^addr_in[31:18];

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

    assign tx_count = tx_wp - tx_rp;
    assign io_full  = tx_count >= (FIFO_AW+1)'(DEPTH - 2);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign rx_ready = ~rx_full;

    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign tx_pop      = ~tx_empty & tx_ready;
    assign tx_push_req = data_sel & wr_in;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign rx_push     = rx_valid & ~rx_full;
    assign rx_pop      = data_sel & ~wr_in & ~rx_empty;

    assign status = {5'b0, tx_ovf, ~rx_empty, tx_full};

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_a] <= data_in;
        if (tx_push)
            tx_mem[tx_wp[FIFO_AW-1:0]] <= data_in;
        if (rx_push)
            rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            tx_ovf   <= 1'b0;
            halt     <= 1'b0;
            data_out <= 8'h00;
        end else begin
            if (tx_pop)
                tx_rp <= tx_rp + 1'b1;
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (rx_push)
                rx_wp <= rx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            if (tx_push_req & tx_full & ~tx_pop)
                tx_ovf <= 1'b1;
            if (stat_sel & wr_in)
                halt <= 1'b1;
            if (rdy & ~wr_in) begin
                if (!io)
                    data_out <= mem[ram_a];
                else if (off == 3'd0)
                    data_out <= rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
                else if (off == 3'd4)
                    data_out <= status;
                else
                    data_out <= 8'h00;
            end
        end
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_AW, 17, byte-RAM address width (2^17 bytes).
REQ-002 Parameter FIFO_AW, 3, log2 depth of each I/O FIFO (8 entries).
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; low freezes all CPU-side state.
REQ-006 addr_in  input  32  byte address from memory initiator.
REQ-007 data_in  input  8  write byte from initiator.
REQ-008 wr_in  input  1  1 = write this cycle, 0 = read.
REQ-009 data_out  output  8  registered read byte, valid one cycle after address.
REQ-010 tx_data  output  8  head byte of TX FIFO.
REQ-011 tx_valid  output  1  TX FIFO non-empty.
REQ-012 tx_ready  input  1  external sink accepts tx_data when tx_valid & tx_ready.
REQ-013 rx_data  input  8  byte from external source.
REQ-014 rx_valid  input  1  rx_data present.
REQ-015 rx_ready  output  1  RX FIFO not full; byte accepted when rx_valid & rx_ready.
REQ-016 io_full  output  1  TX FIFO count >= depth-2; top level uses it to drop rdy.
REQ-017 halt  output  1  sticky; program-end write seen.

Function
REQ-018 Decode: addr_in[17:16]==2'b11 = I/O region; otherwise RAM at addr_in[RAM_AW-1:0]; bits above 17 ignored.
REQ-019 RAM write: wr_in=1 & rdy & RAM region -> mem[addr] <= data_in at posedge.
REQ-020 RAM read: wr_in=0 & rdy & RAM region -> data_out <= mem[addr] at posedge (latency exactly 1 cycle).
REQ-021 Read-after-write same address on consecutive cycles returns the newly written byte.
REQ-022 I/O offset = addr_in[2:0]; 0x30000 = data port, 0x30004 = status/control; other offsets: reads return 0x00, writes ignored.
REQ-023 Write 0x30000: push data_in into TX FIFO; if full, byte dropped and sticky tx_ovf set.
REQ-024 Read 0x30000: pop RX FIFO head into data_out; if empty, data_out <= 0x00, no pointer change.
REQ-025 Each rdy cycle addressing 0x30000 with wr_in=0 pops one byte (a 4-byte read pops up to 4).
REQ-026 Read 0x30004: data_out <= {5'b0, tx_ovf, rx_nonempty, tx_full}.
REQ-027 Write 0x30004: any value sets halt=1; halt stays 1 until rst.
REQ-028 rdy=0: no RAM write, no CPU-side push/pop, data_out holds, halt/tx_ovf hold.
REQ-029 External side independent of rdy: TX pop on tx_valid & tx_ready; RX push on rx_valid & rx_ready.
REQ-030 Simultaneous push and pop on same FIFO: both occur, count unchanged; when full, pop frees the slot first so push succeeds (no overflow).
REQ-031 Simultaneous pop and push on empty FIFO: pop sees empty (returns 0x00 / tx_valid stays 0 that cycle), push lands, count=1.
REQ-032 FIFO pointers FIFO_AW+1 bits; wrap modulo depth; full = MSBs differ & LSBs equal; empty = pointers equal.
REQ-033 tx_data, tx_valid, rx_ready, io_full derived combinationally from FIFO pointers/storage registers only.

Reset
REQ-034 rst=1 at posedge: data_out=0, both FIFOs empty (tx_valid=0, rx_ready=1, io_full=0), tx_ovf=0, halt=0; RAM contents not cleared.
REQ-035 rst overrides rdy and any in-flight push/pop in the same cycle; FIFO contents discarded.
REQ-036 First cycle after rst deasserts: fully operational.

Verification
REQ-037 Write 0xA5 to 0x00010, next cycle read 0x00010 -> data_out=0xA5 one cycle later; addr 0x00000 idle reads never touch FIFOs.
REQ-038 Write bytes 1..9 to 0x30000 with tx_ready=0 -> 8 queued, 9th dropped, status read = 0x05, io_full=1 after 6th push; then tx_ready=1 -> tx_data 1..8 in order.
REQ-039 rx_valid with 0x41,0x42, then 4-byte read at 0x30000 -> data_out 0x41,0x42,0x00,0x00; rx_ready stays 1.
REQ-040 TX full, same cycle CPU push 0x77 and tx_ready=1 -> head popped, 0x77 stored, tx_ovf stays 0.
REQ-041 rdy=0 while wr_in=1 to 0x00020 and 0x30000 -> RAM and TX FIFO unchanged, data_out held; external RX push still accepted.
REQ-042 Write 0x30004 -> halt=1 next cycle, held; rst mid TX drain -> tx_valid=0, halt=0 next cycle.
